// File: rtl/nebula_wb_pkg.sv
// Shared types and constants for the Wishbone-to-register-bus bridge.
// No logic here; purely combinational constants, no latency or backpressure.
package nebula_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACK,
    DRAIN
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA      = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEFAULT_ADDR_MASK = 32'hFFFF_0000;

endpackage

// File: rtl/wb_addr_decode.sv
// Window hit compare: combinational, zero latency, no backpressure.
module wb_addr_decode
  import nebula_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEFAULT_ADDR_MASK
) (
  input  logic [31:0] adr_i,
  output logic        hit_o
);

  assign hit_o = ((adr_i & ADDR_MASK) == BASE_ADDR);

endmodule

// File: rtl/wb_regbus_bridge.sv
// Wishbone classic slave to req/gnt/rvalid register bus; one access at a time, ack >= 2 cycles after stb,
// stalls on gnt/rvalid. WB_TIMEOUT_EN adds a force-ack watchdog (TIMEOUT_CYCLES).
module wb_regbus_bridge
  import nebula_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK      = DEFAULT_ADDR_MASK,
  parameter int          REG_AW         = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  output logic [3:0]        reg_be_o,
  input  logic              reg_gnt_i,
  input  logic              reg_rvalid_i,
  input  logic [31:0]       reg_rdata_i,
  output logic              busy_o,
  output logic              timeout_o
);

  state_e              state_q;
  logic                ack_q;
  logic [31:0]         dat_q;
  logic                req_q;
  logic                we_q;
  logic [REG_AW-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                tmo_q;
  logic                hit;
  logic                tmo_hit;
  logic [31:0]         resp_dat;

  wb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .adr_i (wbs_adr_i),
    .hit_o (hit)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is zero whenever idle, so it is already clear on REQ entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == REQ || state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tmo_hit = (state_q == REQ || state_q == WAIT) && (cnt_d == CW'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // Writes return zero rather than whatever the register bus drives on rdata.
  assign resp_dat = we_q ? 32'h0 : reg_rdata_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      tmo_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i && hit) begin
            addr_q  <= wbs_adr_i[REG_AW-1:0];
            wdata_q <= wbs_dat_i;
            we_q    <= wbs_we_i;
            be_q    <= wbs_sel_i;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ, WAIT: begin
          if (tmo_hit) begin
            req_q   <= 1'b0;
            ack_q   <= 1'b1;
            dat_q   <= TIMEOUT_DATA;
            tmo_q   <= 1'b1;
            state_q <= ACK;
          end else if ((state_q == WAIT || reg_gnt_i) && reg_rvalid_i) begin
            // A response that lands after the master left is simply dropped.
            req_q <= 1'b0;
            if (wbs_cyc_i) begin
              ack_q   <= 1'b1;
              dat_q   <= resp_dat;
              state_q <= ACK;
            end else begin
              state_q <= IDLE;
            end
          end else if (state_q == REQ && reg_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= wbs_cyc_i ? WAIT : DRAIN;
          end else if (!wbs_cyc_i) begin
            req_q   <= 1'b0;
            state_q <= (state_q == REQ) ? IDLE : DRAIN;
          end
        end
        ACK:     state_q <= IDLE;
        DRAIN:   if (reg_rvalid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign reg_req_o   = req_q;
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = be_q;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = tmo_q;

endmodule

// File: doc/wb_regbus_bridge.md
Name: wb_regbus_bridge

Overview:
- Wishbone classic slave front-end inside nebula_ii.
- Consumes the management-SoC wbs_* bus forwarded by the user project wrapper.
- Decodes the user address window and converts each single-beat access into a req/gnt/rvalid transaction on the internal register bus.
- Returns wbs_ack_o and read data to the SoC; handles one transaction at a time (no pipelining).

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the decoded window.
- ADDR_MASK, 32'hFFFF_0000, bits compared against BASE_ADDR. Hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR).
- REG_AW, 16, register-bus byte-address width; equals wbs_adr_i[REG_AW-1:0].
- TIMEOUT_CYCLES, 255, cycles before a stalled access is force-acked. Used only with WB_TIMEOUT_EN; must be >= 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o is high
- reg_req_o  out  1  register-bus request
- reg_we_o  out  1  write flag
- reg_addr_o  out  REG_AW  byte offset
- reg_wdata_o  out  32  write data
- reg_be_o  out  4  byte enables
- reg_gnt_i  in  1  request accepted
- reg_rvalid_i  in  1  response valid; required for both reads and writes
- reg_rdata_i  in  32  read data (ignored for writes)
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (asynchronous, wb_rst_i=1):
  - State = IDLE.
  - All outputs 0, including wbs_dat_o, reg_addr_o, reg_wdata_o and reg_be_o.
  - Timeout counter = 0.
- States: IDLE, REQ, WAIT, ACK, DRAIN.
- IDLE:
  - When cyc & stb & hit: register adr[REG_AW-1:0], dat, we and sel into the reg_* outputs, then go to REQ.
  - A miss is ignored: no ack, stay in IDLE.
- REQ:
  - reg_req_o=1; the reg_* outputs are held stable until gnt.
  - gnt & rvalid in the same cycle: capture rdata, go to ACK.
  - gnt alone: go to WAIT.
  - cyc=0 before gnt (abort): go to IDLE with no ack.
- WAIT:
  - reg_req_o=0.
  - rvalid: capture rdata (writes capture 0), go to ACK.
  - cyc=0 (abort): go to DRAIN.
- ACK:
  - wbs_ack_o=1 and wbs_dat_o=captured data for exactly one cycle, then IDLE.
  - wbs_dat_o returns to 0 the following cycle.
- DRAIN: wait for rvalid, discard the data, go to IDLE; never ack.
- Latency:
  - Minimum hit-to-ack is 2 cycles: stb in cycle 0, REQ in cycle 1 with gnt+rvalid, ack in cycle 2.
  - A new access is accepted no earlier than the cycle after ACK.
- After ACK the master is expected to drop stb. A still-asserted stb in IDLE is treated as a new access, per Wishbone classic.
- rvalid or gnt arriving in IDLE or ACK is ignored.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: go to ACK with captured data 32'hDEAD_BEEF, pulse timeout_o for 1 cycle, and drop reg_req_o.
  - Any late rvalid is ignored.
  - Timeout has priority over a same-cycle rvalid.
- Not defined:
  - No counter logic is present and REQ/WAIT wait indefinitely.
  - timeout_o is tied to 0.

Decomposition:
- Package nebula_wb_pkg holds:
  - state enum (IDLE, REQ, WAIT, ACK, DRAIN);
  - TIMEOUT_DATA = 32'hDEAD_BEEF;
  - default BASE_ADDR / ADDR_MASK constants.
- One natural sub-module: wb_addr_decode, a combinational hit compare. Everything else stays flat.

Test Plan:
- Write, adr=0x3000_0010, dat=0xA5A5_1234, sel=4'b0011, gnt+rvalid in the first REQ cycle -> reg_addr_o=0x0010, reg_wdata_o=0xA5A5_1234, reg_be_o=4'b0011, reg_we_o=1; ack 2 cycles after stb.
- Read, adr=0x3000_0004, gnt after 3 cycles, rvalid 2 cycles later with rdata=0xCAFE_F00D -> one ack cycle with wbs_dat_o=0xCAFE_F00D; busy_o high throughout; wbs_dat_o=0 afterwards.
- Miss, adr=0x2000_0000 -> reg_req_o stays 0, no ack, busy_o=0.
- Abort: cyc dropped in WAIT, rvalid 4 cycles later -> no ack, DRAIN, then IDLE; a subsequent read completes normally.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously, IDLE after release.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and gnt never given -> ack with 0xDEAD_BEEF 8 cycles after REQ entry; timeout_o pulses once.
